// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues word-aligned requests to instruction
// memory, collects the in-order responses into a small prefetch buffer, and
// presents the buffer head to decode. A redirect (taken branch/jump) flushes
// the buffer and restarts fetch at the new target. Responses to requests that
// were still in flight at the redirect are counted and silently dropped.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     prefetch-buffer entries (power of 2, 2..16)
//
// Ports
//   clk, reset_n                     clock, synchronous active-low reset
//   fetch_en                         allows new memory requests
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_rsp_valid/data              in-order response channel, no backpressure
//   redirect_valid/pc                flush and refetch from redirect_pc
//   instr_valid/ready/data/pc        buffer head toward decode
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_aligned;
  logic          req_fire, rsp_fire, push, pop;

  // Targets are forced to word alignment, so the two low bits are never used.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Buffered plus in-flight entries bound new requests: every accepted request
  // already owns a buffer slot, so a response can never find the buffer full.
  assign inflight       = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = fetch_en & (inflight < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid & (outst_q != '0);
  // Kept responses are written unless they are stale or being flushed now.
  assign push     = rsp_fire & (drop_q == '0) & ~redirect_valid;

  assign instr_valid = (count_q != '0);
  assign instr_data  = instr_valid ? mem_q[head_q] : 32'h0;
  assign instr_pc    = head_pc_q;
  assign pop         = instr_valid & instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop) begin
      head_d    = head_q + PW'(1);
      head_pc_d = head_pc_q + 32'd4;
    end

    // The flush wins over the updates above, but it is applied after them:
    // a decode pop this cycle has already happened, and everything still in
    // flight once this cycle's accept/response settle becomes stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      head_pc_d  = redirect_aligned;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Buffer storage needs no reset; count_q decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= imem_rsp_data;
    end
  end

endmodule
